// File: rtl/ifetch_axi_reader.sv
// Instruction-fetch stage: single-beat AXI4 read master that fetches 32-bit words
// sequentially from a start PC, tags each with its PC, buffers them in a small FIFO
// and hands them to decode over valid/ready. Supports redirect with flush and traps
// on read errors.
//
// Ports:
//   ACLK, ARESETN               clock, synchronous active-low reset
//   START / START_ADDR          begin fetching (honoured in IDLE or ERROR only)
//   REDIRECT / REDIRECT_ADDR    flush buffer and resume at new PC (any state)
//   BUSY, ERR                   state != IDLE; sticky read-error flag
//   INST_VALID/DATA/PC, INST_READY   decode-side instruction stream
//   M_AXI_AR*, M_AXI_R*         AXI4 read address / read data channels
module ifetch_axi_reader #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH         = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          START,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] START_ADDR,
    input  logic                          REDIRECT,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] REDIRECT_ADDR,
    output logic                          BUSY,
    output logic                          ERR,
    output logic                          INST_VALID,
    output logic [C_M_AXI_DATA_WIDTH-1:0] INST_DATA,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] INST_PC,
    input  logic                          INST_READY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW    = C_M_AXI_DATA_WIDTH;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_DATA  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } entry_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] araddr_q, araddr_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          err_q, err_d;
    logic          discard_q, discard_d;
    logic          busy_q;

    logic          flush_c;
    logic          push_c;
    logic          pop_c;
    logic          ar_hs_c;
    logic          r_hs_c;

    entry_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               inst_valid_q;

    // RLAST carries no information for single-beat reads; low address bits are masked
    logic unused_ok;
    assign unused_ok = ^{M_AXI_RLAST, START_ADDR[1:0], REDIRECT_ADDR[1:0]};

    assign ar_hs_c = arvalid_q & M_AXI_ARREADY;
    assign r_hs_c  = M_AXI_RVALID & rready_q;
    assign pop_c   = inst_valid_q & INST_READY;

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        err_d     = err_q;
        discard_d = discard_q;
        flush_c   = 1'b0;
        push_c    = 1'b0;

        case (state_q)
            S_IDLE, S_ERROR: begin
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                if (REDIRECT) begin
                    pc_d      = {REDIRECT_ADDR[AW-1:2], 2'b00};
                    flush_c   = 1'b1;
                    err_d     = 1'b0;
                    discard_d = 1'b0;
                    state_d   = S_ADDR;
                end else if (START) begin
                    pc_d      = {START_ADDR[AW-1:2], 2'b00};
                    flush_c   = 1'b1;
                    err_d     = 1'b0;
                    discard_d = 1'b0;
                    state_d   = S_ADDR;
                end
            end

            S_ADDR: begin
                if (ar_hs_c) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_DATA;
                end else if (!arvalid_q && !REDIRECT &&
                             (count_q < CNT_W'(FIFO_DEPTH))) begin
                    // Only issue a read when the buffer has room for its beat
                    arvalid_d = 1'b1;
                    araddr_d  = pc_q;
                end
                if (REDIRECT) begin
                    flush_c = 1'b1;
                    pc_d    = {REDIRECT_ADDR[AW-1:2], 2'b00};
                    // An address already on the bus must complete; drop its beat
                    if (arvalid_q) begin
                        discard_d = 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (r_hs_c) begin
                    rready_d = 1'b0;
                    state_d  = S_ADDR;
                    if (discard_q || REDIRECT) begin
                        discard_d = 1'b0;
                    end else if (M_AXI_RRESP == 2'b00) begin
                        push_c = 1'b1;
                        pc_d   = pc_q + AW'(4);
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end
                end
                if (REDIRECT) begin
                    flush_c = 1'b1;
                    pc_d    = {REDIRECT_ADDR[AW-1:2], 2'b00};
                    if (!r_hs_c) begin
                        discard_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state register
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            err_q     <= err_d;
            discard_q <= discard_d;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    // Instruction buffer occupancy; pushes never coincide with a flush
    always_comb begin
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inst_valid_q <= 1'b0;
        end else if (flush_c) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q      <= count_d;
            inst_valid_q <= (count_d != '0);
        end
    end

    // Buffer storage, no reset needed: contents only observed while valid
    always_ff @(posedge ACLK) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= '{pc: pc_q, data: M_AXI_RDATA};
        end
    end

    assign BUSY          = busy_q;
    assign ERR           = err_q;
    assign INST_VALID    = inst_valid_q;
    assign INST_DATA     = fifo_mem[rd_ptr_q].data;
    assign INST_PC       = fifo_mem[rd_ptr_q].pc;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;

endmodule

// File: tb/tb_ifetch_axi_reader.sv
// Bench for ifetch_axi_reader: randomized AXI slave and consumer, a reference model
// of the fetch stream (expected PC sequence per start/redirect) feeding a scoreboard,
// and a monitor that checks every accepted instruction against it.
module tb_ifetch_axi_reader;

    localparam int unsigned DEPTH = 4;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        START = 1'b0;
    logic [31:0] START_ADDR = '0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_ADDR = '0;
    logic        BUSY, ERR, INST_VALID;
    logic [31:0] INST_DATA, INST_PC;
    logic        INST_READY = 1'b0;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY = 1'b0;
    logic [31:0] M_AXI_RDATA = '0;
    logic [1:0]  M_AXI_RRESP = '0;
    logic        M_AXI_RLAST = 1'b0;
    logic        M_AXI_RVALID = 1'b0;
    logic        M_AXI_RREADY;

    ifetch_axi_reader dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .START         (START),
        .START_ADDR    (START_ADDR),
        .REDIRECT      (REDIRECT),
        .REDIRECT_ADDR (REDIRECT_ADDR),
        .BUSY          (BUSY),
        .ERR           (ERR),
        .INST_VALID    (INST_VALID),
        .INST_DATA     (INST_DATA),
        .INST_PC       (INST_PC),
        .INST_READY    (INST_READY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARLEN   (M_AXI_ARLEN),
        .M_AXI_ARSIZE  (M_AXI_ARSIZE),
        .M_AXI_ARBURST (M_AXI_ARBURST),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RLAST   (M_AXI_RLAST),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    // Reference model state
    logic [31:0] fetch_pc = '0;
    bit running   = 0;
    bit busy_exp  = 0;
    bit err_exp   = 0;
    bit drop_next = 0;
    bit inflight  = 0;

    // Slave state
    bit          s_pend   = 0;
    bit          s_rvalid = 0;
    int          s_cnt    = 0;
    logic [31:0] s_addr   = '0;
    bit          s_err    = 0;

    // Stimulus knobs and requests
    int unsigned ready_pct   = 100;
    int unsigned arready_pct = 100;
    int unsigned rmin = 0;
    int unsigned rmax = 0;
    int unsigned err_pct = 0;
    bit          use_err = 0;
    logic [31:0] err_addr = '0;
    bit          start_req = 0;
    logic [31:0] start_addr = '0;
    bit          redir_req = 0;
    logic [31:0] redir_addr = '0;
    bit          rst_req = 0;

    // Post-edge expectations derived from the previous cycle
    bit          was_reset = 0;
    bit          was_redirect = 0;
    bit          hold_ar = 0;
    logic [31:0] hold_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Predict the effect of the upcoming clock edge from current inputs/outputs
    task automatic model_update();
        bit ar_hs, r_hs, run_before;
        ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
        r_hs  = M_AXI_RVALID && M_AXI_RREADY;
        run_before   = running;
        was_reset    = !ARESETN;
        was_redirect = ARESETN && REDIRECT;
        hold_ar      = ARESETN && M_AXI_ARVALID && !M_AXI_ARREADY;
        hold_addr    = M_AXI_ARADDR;
        if (!ARESETN) begin
            sb.delete();
            running = 0; busy_exp = 0; err_exp = 0; drop_next = 0; inflight = 0;
            s_pend = 0; s_rvalid = 0;
            return;
        end
        if (r_hs) s_rvalid = 0;
        if (ar_hs) begin
            s_pend = 1;
            s_cnt  = int'($urandom_range(rmax, rmin));
            s_addr = M_AXI_ARADDR;
            s_err  = (use_err && M_AXI_ARADDR == err_addr) || ($urandom_range(0, 99) < err_pct);
        end
        if (s_pend) begin
            if (s_cnt == 0) begin
                s_rvalid = 1;
                s_pend   = 0;
            end else begin
                s_cnt--;
            end
        end
        if (ar_hs && !drop_next) check("araddr", M_AXI_ARADDR, fetch_pc);
        if (REDIRECT) begin
            drop_next = M_AXI_ARVALID || (inflight && !r_hs);
            fetch_pc  = REDIRECT_ADDR & 32'hFFFF_FFFC;
            sb.delete();
            running = 1; busy_exp = 1; err_exp = 0;
        end else begin
            if (r_hs) begin
                if (drop_next) begin
                    drop_next = 0;
                end else if (M_AXI_RRESP == 2'b00) begin
                    sb.push_back('{pc: fetch_pc, data: mem_word(fetch_pc)});
                    fetch_pc = fetch_pc + 32'd4;
                end else begin
                    err_exp = 1;
                    running = 0;
                end
            end
            if (START && !run_before) begin
                fetch_pc = START_ADDR & 32'hFFFF_FFFC;
                sb.delete();
                running = 1; busy_exp = 1; err_exp = 0; drop_next = 0;
            end
        end
        if (ar_hs) inflight = 1;
        if (r_hs) inflight = 0;
    endtask

    // One clock: post-edge checks, drive inputs, then model the next edge
    task automatic step();
        @(posedge ACLK);
        #1;
        if (was_reset) begin
            check("rst_arvalid", M_AXI_ARVALID, 0);
            check("rst_rready", M_AXI_RREADY, 0);
            check("rst_araddr", M_AXI_ARADDR, 0);
            check("rst_inst_valid", INST_VALID, 0);
        end else begin
            if (was_redirect) check("flush_inst_valid", INST_VALID, 0);
            if (hold_ar) begin
                check("ar_hold_valid", M_AXI_ARVALID, 1);
                check("ar_hold_addr", M_AXI_ARADDR, hold_addr);
            end
        end
        check("err", ERR, err_exp);
        check("busy", BUSY, busy_exp);
        check("arvalid_gate", M_AXI_ARVALID && (!running || sb.size() >= DEPTH), 0);

        ARESETN       = !rst_req;
        START         = start_req;
        START_ADDR    = start_addr;
        REDIRECT      = redir_req;
        REDIRECT_ADDR = redir_addr;
        start_req = 0; redir_req = 0; rst_req = 0;
        INST_READY    = ($urandom_range(0, 99) < ready_pct);
        M_AXI_ARREADY = ($urandom_range(0, 99) < arready_pct);
        M_AXI_RVALID  = s_rvalid;
        M_AXI_RLAST   = s_rvalid;
        M_AXI_RDATA   = s_rvalid ? mem_word(s_addr) : $urandom;
        M_AXI_RRESP   = s_err ? 2'b10 : 2'b00;
        #6;
        model_update();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_rready(input int budget, input string name);
        int n = 0;
        while (!M_AXI_RREADY && n < budget) begin
            step();
            n++;
        end
        check(name, M_AXI_RREADY, 1);
    endtask

    // Monitor: every accepted instruction must match the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (ARESETN && INST_VALID && INST_READY) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst actual_pc=%h required=none", INST_PC);
                end else begin
                    e = sb.pop_front();
                    check("inst_pc", INST_PC, e.pc);
                    check("inst_data", INST_DATA, e.data);
                    pops++;
                end
            end
        end
    end

    initial begin
        int n;
        rst_req = 1;
        step();
        step();
        check("arlen", 32'(M_AXI_ARLEN), 0);
        check("arsize", 32'(M_AXI_ARSIZE), 2);
        check("arburst", 32'(M_AXI_ARBURST), 1);

        // Sequential fetch, zero-wait slave
        start_req = 1; start_addr = 32'h1000;
        run(40);

        // Consumer stalls: buffer fills, fetch must stop, then resume without loss
        ready_pct = 0;
        run(40);
        check("full_inst_valid", INST_VALID, 1);
        check("full_arvalid", M_AXI_ARVALID, 0);
        ready_pct = 100;
        run(30);

        // Redirect while a read is in the data phase
        rmin = 2; rmax = 3; arready_pct = 50;
        wait_rready(50, "reach_data_for_redirect");
        redir_req = 1; redir_addr = 32'h2000;
        run(40);

        // Error response at 0x1008, then restart at 0x3000
        rmin = 0; rmax = 1; arready_pct = 100;
        rst_req = 1;
        step();
        use_err = 1; err_addr = 32'h1008;
        start_req = 1; start_addr = 32'h1000;
        n = 0;
        while (!ERR && n < 100) begin
            step();
            n++;
        end
        check("err_seen", ERR, 1);
        run(10);
        check("err_arvalid", M_AXI_ARVALID, 0);
        use_err = 0;
        start_req = 1; start_addr = 32'h3000;
        run(30);

        // PC wrap at the top of the address space
        rst_req = 1;
        step();
        start_req = 1; start_addr = 32'hFFFF_FFFC;
        run(30);

        // Reset in the middle of a read
        rmin = 2; rmax = 3; arready_pct = 30;
        wait_rready(60, "reach_data_for_reset");
        rst_req = 1;
        run(3);

        // Randomized traffic
        rmin = 0; rmax = 3; arready_pct = 60; err_pct = 1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 49) == 0) ready_pct = $urandom_range(0, 100);
            if ($urandom_range(0, 99) < 2) begin
                redir_req  = 1;
                redir_addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : $urandom;
            end
            if ($urandom_range(0, 99) < 5) begin
                start_req  = 1;
                start_addr = $urandom;
            end
            if ($urandom_range(0, 999) < 2) rst_req = 1;
            step();
        end
        ready_pct = 100; err_pct = 0;
        run(20);
        check("progress", 32'(pops > 100), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
